burst_bus_arbiter: RTL and testbench



---
 rtl/burst_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_burst_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_bus_arbiter.sv
// burst_bus_arbiter: shares one SDRAM burst-bus port between a high-priority video reader
// and a starvation-guarded host agent, serialising whole bursts and routing read data back.
module burst_bus_arbiter #(
    parameter int ADDR_W       = 21,
    parameter int DATA_W       = 64,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cmd_en,
    input  logic                m0_cmd,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wr_data,
    input  logic [DATA_W/8-1:0] m0_data_mask,
    output logic                m0_ack,
    output logic                m0_wr_next,
    output logic [DATA_W-1:0]   m0_rd_data,
    output logic                m0_rd_data_valid,
    input  logic                m1_cmd_en,
    input  logic                m1_cmd,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wr_data,
    input  logic [DATA_W/8-1:0] m1_data_mask,
    output logic                m1_ack,
    output logic                m1_wr_next,
    output logic [DATA_W-1:0]   m1_rd_data,
    output logic                m1_rd_data_valid,
    output logic                mem_cmd_en,
    output logic                mem_cmd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_cmd_ready,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic [DATA_W/8-1:0] mem_data_mask,
    input  logic [DATA_W-1:0]   mem_rd_data,
    input  logic                mem_rd_data_valid,
    output logic                busy,
    output logic                owner,
    output logic                stray_data
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t              state, state_n;
    logic                owner_n, cmd_n, cmd_en_n, stray_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [SW-1:0]       starve_cnt, starve_n;
    logic [CW-1:0]       word_cnt, word_n;
    logic                grant0, grant1, accept, consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            mem_cmd    <= 1'b0;
            mem_addr   <= '0;
            mem_cmd_en <= 1'b0;
            starve_cnt <= '0;
            word_cnt   <= '0;
            stray_data <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            mem_cmd    <= cmd_n;
            mem_addr   <= addr_n;
            mem_cmd_en <= cmd_en_n;
            starve_cnt <= starve_n;
            word_cnt   <= word_n;
            stray_data <= stray_n;
        end
    end

    assign grant0  = m0_cmd_en && (!m1_cmd_en || starve_cnt < SW'(STARVE_LIMIT));
    assign grant1  = m1_cmd_en && !grant0;
    assign accept  = state == CMD && mem_cmd_ready;
    // Word 0 of a write goes out in the acceptance cycle itself.
    assign consume = (accept && mem_cmd) || state == WDATA;

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        cmd_n    = mem_cmd;
        addr_n   = mem_addr;
        cmd_en_n = mem_cmd_en;
        starve_n = starve_cnt;
        word_n   = word_cnt;
        stray_n  = stray_data || (mem_rd_data_valid && state != RDATA);
        case (state)
            IDLE: begin
                starve_n = (grant0 && m1_cmd_en)
                         ? ((starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1)
                         : '0;
                if (grant0 || grant1) begin
                    state_n  = CMD;
                    owner_n  = grant1;
                    cmd_n    = grant1 ? m1_cmd : m0_cmd;
                    addr_n   = grant1 ? m1_addr : m0_addr;
                    cmd_en_n = 1'b1;
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    cmd_en_n = 1'b0;
                    word_n   = CW'(1);
                    if (!mem_cmd)
                        state_n = RDATA;
                    else if (BURST_LEN == 1)
                        state_n = IDLE;
                    else
                        state_n = WDATA;
                end
            end
            WDATA: begin
                word_n = word_cnt + 1'b1;
                if (word_cnt == CW'(BURST_LEN - 1)) begin
                    state_n = IDLE;
                    word_n  = '0;
                end
            end
            RDATA: begin
                if (mem_rd_data_valid) begin
                    word_n = word_cnt + 1'b1;
                    if (word_cnt == CW'(BURST_LEN)) begin
                        state_n = IDLE;
                        word_n  = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign m0_ack           = accept && !owner;
    assign m1_ack           = accept && owner;
    assign m0_wr_next       = consume && !owner;
    assign m1_wr_next       = consume && owner;
    assign m0_rd_data_valid = mem_rd_data_valid && state == RDATA && !owner;
    assign m1_rd_data_valid = mem_rd_data_valid && state == RDATA && owner;
    assign m0_rd_data       = mem_rd_data;
    assign m1_rd_data       = mem_rd_data;
    assign mem_wr_data      = owner ? m1_wr_data : m0_wr_data;
    assign mem_data_mask    = owner ? m1_data_mask : m0_data_mask;
    assign busy             = state != IDLE;
endmodule

// File: tb/tb_burst_bus_arbiter.sv
// tb_burst_bus_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_burst_bus_arbiter;
    localparam int AW = 21, DW = 64, BL = 4, LIM = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      en = '0, cmd = '0;
    logic [AW-1:0]   addr [2];
    logic [DW-1:0]   wd [2];
    logic [DW/8-1:0] dm [2];
    logic            ready = 1'b0, rdv = 1'b0;
    logic [DW-1:0]   rdd = '0;
    logic            ack0, ack1, wn0, wn1, rv0, rv1, mem_cmd_en, mem_cmd, busy, owner, stray;
    logic [DW-1:0]   rd0, rd1, mem_wr_data;
    logic [DW/8-1:0] mem_mask;
    logic [AW-1:0]   mem_addr;

    burst_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .m0_cmd_en(en[0]), .m0_cmd(cmd[0]), .m0_addr(addr[0]), .m0_wr_data(wd[0]),
        .m0_data_mask(dm[0]), .m0_ack(ack0), .m0_wr_next(wn0), .m0_rd_data(rd0),
        .m0_rd_data_valid(rv0),
        .m1_cmd_en(en[1]), .m1_cmd(cmd[1]), .m1_addr(addr[1]), .m1_wr_data(wd[1]),
        .m1_data_mask(dm[1]), .m1_ack(ack1), .m1_wr_next(wn1), .m1_rd_data(rd1),
        .m1_rd_data_valid(rv1),
        .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_cmd_ready(ready), .mem_wr_data(mem_wr_data), .mem_data_mask(mem_mask),
        .mem_rd_data(rdd), .mem_rd_data_valid(rdv),
        .busy(busy), .owner(owner), .stray_data(stray)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: one outstanding burst described by owner port, direction, accepted flag and words moved.
    bit            mb, mp, mw, ma, mstray, armed, auto_rd;
    int            mwords, streak;
    logic [AW-1:0] maddr;
    bit            e_ack [2];
    int            n_ack [2], n_wn [2], n_rv [2];
    logic [DW-1:0] wq [$];
    int            dlog [$];
    logic [DW-1:0] words [4];

    task automatic clear_counts();
        for (int p = 0; p < 2; p++) begin
            n_ack[p] = 0; n_wn[p] = 0; n_rv[p] = 0;
        end
        wq.delete();
        dlog.delete();
    endtask

    task automatic compare();
        bit rd_phase, wr_go;
        rd_phase = mb && ma && !mw;
        wr_go    = mb && mw && (ma || ready);
        e_ack[0] = mb && !ma && ready && !mp;
        e_ack[1] = mb && !ma && ready && mp;
        if (ack0) n_ack[0]++;
        if (ack1) n_ack[1]++;
        if (wn0) n_wn[0]++;
        if (wn1) n_wn[1]++;
        if (rv0) n_rv[0]++;
        if (rv1) n_rv[1]++;
        if (ack0 || ack1) dlog.push_back(int'(ack1));
        if (wn0 || wn1) wq.push_back(mem_wr_data);
        if (!armed) return;
        chk("busy", busy, mb);
        chk("cmd_en", mem_cmd_en, mb && !ma);
        chk("mem_cmd", mem_cmd, mw);
        chk("mem_addr", mem_addr, maddr);
        chk("owner", owner, mp);
        chk("stray", stray, mstray);
        chk("ack0", ack0, e_ack[0]);
        chk("ack1", ack1, e_ack[1]);
        chk("wr_next0", wn0, wr_go && !mp);
        chk("wr_next1", wn1, wr_go && mp);
        chk("rd_valid0", rv0, rdv && rd_phase && !mp);
        chk("rd_valid1", rv1, rdv && rd_phase && mp);
        chk("wr_data", mem_wr_data, mp ? wd[1] : wd[0]);
        chk("wr_mask", mem_mask, mp ? dm[1] : dm[0]);
        chk("rd_data0", rd0, rdd);
        chk("rd_data1", rd1, rdd);
    endtask

    task automatic model_step();
        bit p;
        if (rst) begin
            mb = 0; ma = 0; mp = 0; mw = 0; maddr = '0;
            mwords = 0; streak = 0; mstray = 0;
            return;
        end
        if (rdv && !(mb && ma && !mw)) mstray = 1;
        if (!mb) begin
            if (en[0] || en[1]) begin
                p = !(en[0] && (!en[1] || streak < LIM));
                streak = (!p && en[1]) ? ((streak < LIM) ? streak + 1 : LIM) : 0;
                mb = 1; ma = 0; mp = p; mw = cmd[p]; maddr = addr[p]; mwords = 0;
            end else begin
                streak = 0;
            end
        end else if (!ma) begin
            if (ready) begin
                ma = 1;
                mwords = mw ? 1 : 0;
                if (mw && mwords == BL) mb = 0;
            end
        end else if (mw || rdv) begin
            mwords++;
            if (mwords == BL) mb = 0;
        end
    endtask

    task automatic tick();
        if (auto_rd) rdv = mb && ma && !mw && ($urandom % 2 == 0);
        if (rdv) rdd = {$urandom, $urandom};
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = '0; ready = 0; rdv = 0; auto_rd = 0;
        tick();
        armed = 1;
        chk("rst_busy", busy, 0);
        chk("rst_cmd_en", mem_cmd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_owner", owner, 0);
        chk("rst_stray", stray, 0);
        chk("rst_strobes", {ack0, ack1, wn0, wn1, rv0, rv1}, 0);
        rst = 0;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; wd[p] = '0; dm[p] = '0;
        end
        @(negedge clk);
        do_reset();

        // Port 0 read alone
        clear_counts();
        en[0] = 1; cmd[0] = 0; addr[0] = 21'h000100; ready = 1;
        tick();
        chk("t1_cmd_en", mem_cmd_en, 1);
        chk("t1_addr", mem_addr, 21'h000100);
        tick();
        en[0] = 0;
        repeat (4) tick();
        rdv = 1;
        repeat (4) tick();
        rdv = 0;
        chk("t1_idle", busy, 0);
        chk("t1_ack0", n_ack[0], 1);
        chk("t1_rv0", n_rv[0], 4);
        chk("t1_rv1", n_rv[1], 0);

        // Port 1 write burst
        clear_counts();
        for (int k = 0; k < 4; k++) words[k] = {$urandom, $urandom};
        en[1] = 1; cmd[1] = 1; addr[1] = 21'h1FFFFC; wd[1] = words[0]; dm[1] = 8'hA5;
        tick();
        chk("t2_addr", mem_addr, 21'h1FFFFC);
        for (int k = 0; k < 4; k++) begin
            wd[1] = words[k];
            tick();
            if (k == 0) en[1] = 0;
        end
        chk("t2_idle", busy, 0);
        chk("t2_wn1", n_wn[1], 4);
        chk("t2_wn0", n_wn[0], 0);
        for (int k = 0; k < 4; k++)
            chk("t2_word", (k < wq.size()) ? wq[k] : 64'hDEAD, words[k]);

        // Starvation guard: both ports keep requesting reads
        do_reset();
        clear_counts();
        en = 2'b11; cmd = 2'b00; ready = 1; auto_rd = 1;
        for (int g = 0; g < 3000 && dlog.size() < 18; g++) tick();
        en = '0;
        run_until_idle(200, "t3_idle");
        chk("t3_grants", dlog.size(), 18);
        for (int i = 0; i < 18; i++)
            chk("t3_order", (i < dlog.size()) ? dlog[i] : 7, (i == 8 || i == 17) ? 1 : 0);

        // Back-pressure and late cancel
        do_reset();
        clear_counts();
        a = AW'($urandom);
        en[0] = 1; cmd[0] = 0; addr[0] = a; ready = 0;
        tick();
        for (int c = 1; c <= 7; c++) begin
            chk("t4_cmd_en", mem_cmd_en, 1);
            chk("t4_addr", mem_addr, a);
            if (c == 3) en[0] = 0;
            tick();
        end
        ready = 1;
        tick();
        chk("t4_ack0", n_ack[0], 1);
        auto_rd = 1;
        run_until_idle(200, "t4_idle");
        auto_rd = 0;
        chk("t4_rv0", n_rv[0], 4);

        // Reset in the middle of a read
        do_reset();
        clear_counts();
        en[1] = 1; cmd[1] = 0; addr[1] = AW'($urandom); ready = 1;
        tick();
        tick();
        en[1] = 0;
        rdv = 1;
        tick();
        tick();
        rdv = 0;
        chk("t5_rv1_pre", n_rv[1], 2);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_busy", busy, 0);
        chk("t5_cmd_en", mem_cmd_en, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_owner", owner, 0);
        chk("t5_stray_clr", stray, 0);
        clear_counts();
        rdv = 1;
        tick();
        tick();
        rdv = 0;
        chk("t5_stray", stray, 1);
        chk("t5_rv", n_rv[0] + n_rv[1], 0);
        chk("t5_idle", busy, 0);

        // Randomized traffic
        do_reset();
        auto_rd = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!en[p]) begin
                    if ($urandom % 3 == 0) begin
                        en[p] = 1; cmd[p] = 1'($urandom); addr[p] = AW'($urandom);
                    end
                end else if (mb && !ma && mp == 1'(p) && $urandom % 16 == 0) begin
                    en[p] = 0;
                end
                wd[p] = {$urandom, $urandom};
                dm[p] = 8'($urandom);
            end
            ready = ($urandom % 4 != 0);
            tick();
            for (int p = 0; p < 2; p++) begin
                if (e_ack[p]) begin
                    if ($urandom % 2 == 0) en[p] = 0;
                    else begin
                        cmd[p] = 1'($urandom); addr[p] = AW'($urandom);
                    end
                end
            end
        end
        en = '0;
        run_until_idle(500, "rand_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
